// File: rtl/wb_queue_pkg.sv
// Shared types and sizing helpers for the writeback queue.
// The optional forwarding path is enabled with the WB_QUEUE_FWD_EN macro.
package wb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] wreg;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

    // Occupancy needs one extra bit so a full queue (Count == DEPTH) is representable.
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_queue_match.sv
// Pending-write lookup for one operand query over age-ordered entries.
// Index 0 is the oldest entry; with WB_QUEUE_FWD_EN the youngest hit's data is returned.
module wb_match
    import wb_pkg::*;
#(
    parameter int N      = 5,
    parameter int ADDR_W = ADDR_W_DEF
`ifdef WB_QUEUE_FWD_EN
    ,
    parameter int DATA_W = DATA_W_DEF
`endif
) (
    input  logic [ADDR_W-1:0]         query,
    input  logic [N-1:0][ADDR_W-1:0]  regs,
    input  logic [N-1:0]              valid,
`ifdef WB_QUEUE_FWD_EN
    input  logic [N-1:0][DATA_W-1:0]  datas,
    output logic [DATA_W-1:0]         fwd_data,
`endif
    output logic                      hit
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        hit = 1'b0;
`ifdef WB_QUEUE_FWD_EN
        fwd_data = '0;
`endif
        for (int i = 0; i < N; i++) begin
            if (valid[i] && (regs[i] == query)) begin
                hit = 1'b1;
`ifdef WB_QUEUE_FWD_EN
                fwd_data = datas[i];
`endif
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// In-order writeback queue in front of the register file write port, with busy scoreboard.
// Define WB_QUEUE_FWD_EN to add Fwd1_data/Fwd2_data bypass outputs.
module wb_queue
    import wb_pkg::*;
#(
    parameter int  DEPTH        = 4,
    parameter int  DATA_W       = DATA_W_DEF,
    parameter int  ADDR_W       = ADDR_W_DEF,
    parameter bit  ZERO_DISCARD = 1'b1,
    localparam int COUNT_W      = count_w(DEPTH)
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Flush,
    input  logic              Alu_valid,
    output logic              Alu_ready,
    input  logic [ADDR_W-1:0] Alu_reg,
    input  logic [DATA_W-1:0] Alu_data,
    input  logic              Ld_valid,
    output logic              Ld_ready,
    input  logic [ADDR_W-1:0] Ld_reg,
    input  logic [DATA_W-1:0] Ld_data,
    input  logic [ADDR_W-1:0] Query1,
    input  logic [ADDR_W-1:0] Query2,
    output logic              Busy1,
    output logic              Busy2,
`ifdef WB_QUEUE_FWD_EN
    output logic [DATA_W-1:0] Fwd1_data,
    output logic [DATA_W-1:0] Fwd2_data,
`endif
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    output logic [COUNT_W-1:0] Count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int N     = DEPTH + 1;

    logic [ADDR_W-1:0] mem_reg  [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  ld_slot;
    logic              ready;
    logic              alu_push;
    logic              ld_push;
    logic              pop;

    // Ready looks only at registered occupancy so both producers can always fit.
    assign ready     = Rst_n && (Count <= COUNT_W'(DEPTH - 2));
    assign Alu_ready = ready;
    assign Ld_ready  = ready;

    // A register-0 transfer still handshakes but leaves no entry behind.
    assign alu_push = Alu_valid && ready && !(ZERO_DISCARD && (Alu_reg == '0));
    assign ld_push  = Ld_valid  && ready && !(ZERO_DISCARD && (Ld_reg  == '0));
    assign pop      = (Count != '0);
    assign ld_slot  = tail + PTR_W'(alu_push);

    // NOTE: storage is not reset; head and Count alone decide which slots are live.
    always_ff @(posedge Clk) begin
        if (alu_push) begin
            mem_reg[tail]  <= Alu_reg;
            mem_data[tail] <= Alu_data;
        end
        if (ld_push) begin
            mem_reg[ld_slot]  <= Ld_reg;
            mem_data[ld_slot] <= Ld_data;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            head          <= '0;
            tail          <= '0;
            Count         <= '0;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else if (Flush) begin
            head          <= '0;
            tail          <= '0;
            Count         <= '0;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            if (pop) begin
                WriteRegister <= mem_reg[head];
                WriteData     <= mem_data[head];
                head          <= head + PTR_W'(1);
            end
            RegWrite <= pop;
            tail     <= tail + PTR_W'(alu_push) + PTR_W'(ld_push);
            Count    <= Count + COUNT_W'(alu_push) + COUNT_W'(ld_push) - COUNT_W'(pop);
        end
    end

    // Present the output stage (oldest) followed by FIFO head..tail to the matchers.
    logic [N-1:0][ADDR_W-1:0] age_reg;
    logic [N-1:0]             age_valid;
`ifdef WB_QUEUE_FWD_EN
    logic [N-1:0][DATA_W-1:0] age_data;
`endif

    always_comb begin
        age_reg[0]   = WriteRegister;
        age_valid[0] = RegWrite;
`ifdef WB_QUEUE_FWD_EN
        age_data[0]  = WriteData;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            age_reg[i+1]   = mem_reg[head + PTR_W'(i)];
            age_valid[i+1] = (COUNT_W'(i) < Count);
`ifdef WB_QUEUE_FWD_EN
            age_data[i+1]  = mem_data[head + PTR_W'(i)];
`endif
        end
    end

    wb_match #(
        .N      (N),
        .ADDR_W (ADDR_W)
`ifdef WB_QUEUE_FWD_EN
        ,
        .DATA_W (DATA_W)
`endif
    ) u_match1 (
        .query    (Query1),
        .regs     (age_reg),
        .valid    (age_valid),
`ifdef WB_QUEUE_FWD_EN
        .datas    (age_data),
        .fwd_data (Fwd1_data),
`endif
        .hit      (Busy1)
    );

    wb_match #(
        .N      (N),
        .ADDR_W (ADDR_W)
`ifdef WB_QUEUE_FWD_EN
        ,
        .DATA_W (DATA_W)
`endif
    ) u_match2 (
        .query    (Query2),
        .regs     (age_reg),
        .valid    (age_valid),
`ifdef WB_QUEUE_FWD_EN
        .datas    (age_data),
        .fwd_data (Fwd2_data),
`endif
        .hit      (Busy2)
    );

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed literal checks plus a randomized run
// compared every cycle against a queue-based model of the writeback behaviour.
`timescale 1ns/1ps
module tb_wb_queue;
    import wb_pkg::*;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam bit ZD     = 1'b1;

    logic              Clk = 1'b0;
    logic              Rst_n = 1'b0;
    logic              Flush = 1'b0;
    logic              Alu_valid = 1'b0;
    logic              Ld_valid = 1'b0;
    logic [ADDR_W-1:0] Alu_reg = '0;
    logic [ADDR_W-1:0] Ld_reg = '0;
    logic [ADDR_W-1:0] Query1 = '0;
    logic [ADDR_W-1:0] Query2 = '0;
    logic [DATA_W-1:0] Alu_data = '0;
    logic [DATA_W-1:0] Ld_data = '0;
    logic              Alu_ready;
    logic              Ld_ready;
    logic              Busy1;
    logic              Busy2;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic [$clog2(DEPTH):0] Count;
`ifdef WB_QUEUE_FWD_EN
    logic [DATA_W-1:0] Fwd1_data;
    logic [DATA_W-1:0] Fwd2_data;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 Clk = ~Clk;

    wb_queue #(
        .DEPTH        (DEPTH),
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .ZERO_DISCARD (ZD)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .Flush         (Flush),
        .Alu_valid     (Alu_valid),
        .Alu_ready     (Alu_ready),
        .Alu_reg       (Alu_reg),
        .Alu_data      (Alu_data),
        .Ld_valid      (Ld_valid),
        .Ld_ready      (Ld_ready),
        .Ld_reg        (Ld_reg),
        .Ld_data       (Ld_data),
        .Query1        (Query1),
        .Query2        (Query2),
        .Busy1         (Busy1),
        .Busy2         (Busy2),
`ifdef WB_QUEUE_FWD_EN
        .Fwd1_data     (Fwd1_data),
        .Fwd2_data     (Fwd2_data),
`endif
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .Count         (Count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pending writes in a queue plus the output stage.
    wb_entry_t         mq[$];
    logic              m_rw = 1'b0;
    logic [ADDR_W-1:0] m_reg = '0;
    logic [DATA_W-1:0] m_data = '0;

    task automatic model_clear();
        mq.delete();
        m_rw   = 1'b0;
        m_reg  = '0;
        m_data = '0;
    endtask

    task automatic model_edge();
        wb_entry_t e;
        bit        rdy;
        rdy = (mq.size() <= DEPTH - 2);
        if (mq.size() > 0) begin
            e      = mq.pop_front();
            m_rw   = 1'b1;
            m_reg  = e.wreg;
            m_data = e.data;
        end else begin
            m_rw = 1'b0;
        end
        if (Alu_valid && rdy && !(ZD && Alu_reg == 0)) mq.push_back('{wreg: Alu_reg, data: Alu_data});
        if (Ld_valid && rdy && !(ZD && Ld_reg == 0)) mq.push_back('{wreg: Ld_reg, data: Ld_data});
    endtask

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) model_clear();
        else if (Flush) model_clear();
        else model_edge();
    end

    function automatic bit exp_busy(input logic [ADDR_W-1:0] q);
        if (ZD && q == 0) return 1'b0;
        if (m_rw && m_reg == q) return 1'b1;
        foreach (mq[i]) if (mq[i].wreg == q) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DATA_W-1:0] exp_fwd(input logic [ADDR_W-1:0] q);
        if (!exp_busy(q)) return '0;
        for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].wreg == q) return mq[i].data;
        if (m_rw && m_reg == q) return m_data;
        return '0;
    endfunction

    always @(negedge Clk) begin
        if (cmp_en) begin
            check("m_regwrite", RegWrite, m_rw);
            check("m_write_register", WriteRegister, m_reg);
            check("m_write_data", WriteData, m_data);
            check("m_count", Count, 64'(mq.size()));
            check("m_alu_ready", Alu_ready, Rst_n && (mq.size() <= DEPTH - 2));
            check("m_ld_ready", Ld_ready, Rst_n && (mq.size() <= DEPTH - 2));
            check("m_busy1", Busy1, exp_busy(Query1));
            check("m_busy2", Busy2, exp_busy(Query2));
`ifdef WB_QUEUE_FWD_EN
            check("m_fwd1", Fwd1_data, exp_fwd(Query1));
            check("m_fwd2", Fwd2_data, exp_fwd(Query2));
`endif
        end
    end

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    task automatic idle();
        Alu_valid = 1'b0;
        Ld_valid  = 1'b0;
        Flush     = 1'b0;
    endtask

    initial begin
        cmp_en = 1'b1;
        repeat (3) @(posedge Clk);
        #2;
        check("rst_alu_ready", Alu_ready, 0);
        check("rst_ld_ready", Ld_ready, 0);
        check("rst_regwrite", RegWrite, 0);
        check("rst_count", Count, 0);
        Rst_n = 1'b1;
        step();
        check("idle_alu_ready", Alu_ready, 1);
        check("idle_ld_ready", Ld_ready, 1);
        check("idle_busy1", Busy1, 0);
        check("idle_busy2", Busy2, 0);

        // Single write latency.
        Query1 = 5'd3; Query2 = 5'd9;
        Alu_valid = 1'b1; Alu_reg = 5'd3; Alu_data = 32'hDEADBEEF;
        step(); idle();
        check("lat_count_e0", Count, 1);
        check("lat_rw_e0", RegWrite, 0);
        check("lat_busy_e0", Busy1, 1);
        step();
        check("lat_rw_e1", RegWrite, 1);
        check("lat_reg_e1", WriteRegister, 3);
        check("lat_data_e1", WriteData, 32'hDEADBEEF);
        check("lat_busy_e1", Busy1, 1);
        step();
        check("lat_rw_e2", RegWrite, 0);
        check("lat_busy_e2", Busy1, 0);
        check("lat_hold_reg", WriteRegister, 3);

        // Dual push ordering.
        Query1 = 5'd6;
        Alu_valid = 1'b1; Alu_reg = 5'd5; Alu_data = 32'h11;
        Ld_valid = 1'b1; Ld_reg = 5'd6; Ld_data = 32'h22;
        step(); idle();
        check("dual_count2", Count, 2);
        check("dual_busy", Busy1, 1);
        step();
        check("dual_first_reg", WriteRegister, 5);
        check("dual_first_data", WriteData, 32'h11);
        check("dual_count1", Count, 1);
        step();
        check("dual_second_reg", WriteRegister, 6);
        check("dual_second_data", WriteData, 32'h22);
        check("dual_count0", Count, 0);
        step();
        check("dual_drained", RegWrite, 0);

        // Register 0 is accepted but discarded.
        Query1 = 5'd0;
        Alu_valid = 1'b1; Alu_reg = 5'd0; Alu_data = 32'h99;
        #1 check("zero_ready", Alu_ready, 1);
        step(); idle();
        check("zero_count", Count, 0);
        check("zero_busy", Busy1, 0);
        step();
        check("zero_rw", RegWrite, 0);
        check("zero_hold_reg", WriteRegister, 6);

        // Fill to 3 entries, then flush.
        Alu_valid = 1'b1; Alu_reg = 5'd1; Alu_data = 32'h101;
        Ld_valid = 1'b1; Ld_reg = 5'd2; Ld_data = 32'h202;
        step();
        Query1 = 5'd8;
        Alu_reg = 5'd4; Alu_data = 32'h404; Ld_reg = 5'd8; Ld_data = 32'h808;
        step(); idle();
        check("fill_count3", Count, 3);
        check("fill_alu_ready", Alu_ready, 0);
        check("fill_ld_ready", Ld_ready, 0);
        check("fill_busy", Busy1, 1);
        Flush = 1'b1; Alu_valid = 1'b1; Alu_reg = 5'd9;
        step(); idle();
        check("flush_count", Count, 0);
        check("flush_rw", RegWrite, 0);
        check("flush_busy", Busy1, 0);
        check("flush_reg", WriteRegister, 0);

`ifdef WB_QUEUE_FWD_EN
        Query1 = 5'd7;
        Alu_valid = 1'b1; Alu_reg = 5'd7; Alu_data = 32'hA;
        step();
        Alu_data = 32'hB;
        step(); idle();
        check("fwd_busy_a", Busy1, 1);
        check("fwd_data_a", Fwd1_data, 32'hB);
        step();
        check("fwd_busy_b", Busy1, 1);
        check("fwd_data_b", Fwd1_data, 32'hB);
        step();
        check("fwd_busy_c", Busy1, 0);
        check("fwd_data_c", Fwd1_data, 0);
`endif

        // Sustained backpressure: both producers every cycle.
        for (int c = 0; c < 20; c++) begin
            Alu_valid = 1'b1; Alu_reg = 5'($urandom_range(1, 7)); Alu_data = $urandom;
            Ld_valid = 1'b1; Ld_reg = 5'($urandom_range(1, 7)); Ld_data = $urandom;
            Query1 = 5'($urandom_range(0, 7)); Query2 = 5'($urandom_range(0, 7));
            step();
        end
        idle();

        // Randomized traffic with occasional flush and one mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            Alu_valid = ($urandom_range(0, 3) != 0);
            Ld_valid  = ($urandom_range(0, 2) != 0);
            Alu_reg   = 5'($urandom_range(0, 7));
            Ld_reg    = 5'($urandom_range(0, 7));
            Alu_data  = $urandom;
            Ld_data   = $urandom;
            Query1    = 5'($urandom_range(0, 7));
            Query2    = 5'($urandom_range(0, 7));
            Flush     = ($urandom_range(0, 49) == 0);
            if (c == 1500) Rst_n = 1'b0;
            if (c == 1503) Rst_n = 1'b1;
            step();
        end
        idle();
        repeat (6) step();
        cmp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
